axis_axi_burst_writer: RTL and testbench

// Parametrised AXI4-Stream to AXI4 write-master bridge: buffers one stream packet
// (terminated by tlast) in an internal FIFO and writes it to memory starting at

---
 rtl/axis_axi_burst_writer.sv | 210 +++++++++++++++++++++
 tb/tb_axis_axi_burst_writer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_axi_burst_writer.sv
// AXI4-Stream to AXI4 write-master bridge: buffers one packet in a FIFO
// and writes it out as INCR bursts of up to BURST_LEN beats, one at a time.
module axis_axi_burst_writer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = 1 + KEEP_W + DATA_W;

    localparam logic [CNT_W-1:0]  BL_C    = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BYTES_C = ADDR_W'(KEEP_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fifo_wr, fifo_rd;
    logic              fifo_empty, fifo_full;
    logic              head_last;
    logic [KEEP_W-1:0] head_keep;
    logic [DATA_W-1:0] head_data;

    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        awlen_q;
    logic [7:0]        beat_q;
    logic              busy_q, done_q, err_q;
    logic              last_seen_q, pkt_sent_q;
    logic [CNT_W-1:0]  burst_beats;

    logic start_acc, aw_load, b_acc, pkt_end;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_wr    = s_axis_tvalid & s_axis_tready;
    assign fifo_rd    = m_axi_wvalid & m_axi_wready;

    assign {head_last, head_keep, head_data} = mem[rd_ptr_q];

    assign burst_beats = (count_q >= BL_C) ? BL_C : count_q;

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

    assign s_axis_tready = busy_q & ~fifo_full & ~last_seen_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'($clog2(KEEP_W));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state_q == S_ADDR);

    assign m_axi_wdata  = head_data;
    assign m_axi_wstrb  = head_keep;
    assign m_axi_wvalid = (state_q == S_DATA) & ~fifo_empty;
    assign m_axi_wlast  = (state_q == S_DATA) & (beat_q == awlen_q);

    assign m_axi_bready = (state_q == S_RESP);

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({fifo_wr, fifo_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // busy_q stays high through the done cycle so a coincident start is dropped
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        aw_load   = 1'b0;
        b_acc     = 1'b0;
        pkt_end   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    start_acc = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (count_q >= BL_C || (last_seen_q && !fifo_empty)) begin
                    aw_load = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_axi_awready) state_d = S_DATA;
            end
            S_DATA: begin
                if (fifo_rd && m_axi_wlast) state_d = S_RESP;
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    b_acc = 1'b1;
                    if (pkt_sent_q) begin
                        pkt_end = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // pkt_sent_q marks the tlast beat leaving the FIFO, i.e. nothing left to send
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            awlen_q     <= '0;
            beat_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
            pkt_sent_q  <= 1'b0;
        end else begin
            done_q <= pkt_end;
            if (done_q) busy_q <= 1'b0;
            if (start_acc) begin
                busy_q      <= 1'b1;
                err_q       <= 1'b0;
                addr_q      <= base_addr;
                last_seen_q <= 1'b0;
                pkt_sent_q  <= 1'b0;
            end
            if (fifo_wr && s_axis_tlast) last_seen_q <= 1'b1;
            if (fifo_rd && head_last) pkt_sent_q <= 1'b1;
            if (aw_load) begin
                awlen_q <= 8'(burst_beats - CNT_W'(1));
                beat_q  <= '0;
            end else if (fifo_rd) begin
                beat_q <= beat_q + 8'd1;
            end
            if (b_acc) begin
                err_q  <= err_q | (m_axi_bresp != 2'b00);
                addr_q <= addr_q
                        + (ADDR_W'(awlen_q) + ADDR_W'(1)) * BYTES_C;
            end
        end
    end

endmodule

// File: tb/tb_axis_axi_burst_writer.sv
// Randomised scoreboard bench for axis_axi_burst_writer: expected AW/W/B
// traffic is derived per packet from the burst-splitting rules.
module tb_axis_axi_burst_writer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BL = 16;
    localparam int FD = 32;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, err;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [DW-1:0] m_axi_wdata;
    logic [KW-1:0] m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;

    always #5 clk = ~clk;

    axis_axi_burst_writer #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .err(err),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] strb;
        logic          last;
    } w_t;

    aw_t        exp_aw[$];
    w_t         exp_w[$];
    bit         exp_err[$];
    logic [1:0] resp_q[$];

    int checks = 0;
    int failures = 0;
    int stall = 0;
    int aw_hs = 0, w_hs = 0, wlast_cnt = 0, b_hs = 0, done_cnt = 0;
    int b_issued = 0;
    int reset_at = 0;
    bit start_on_done = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_err"}, 64'(err), 0);
        chk({tag, "_tready"}, 64'(s_axis_tready), 0);
        chk({tag, "_awvalid"}, 64'(m_axi_awvalid), 0);
        chk({tag, "_wvalid"}, 64'(m_axi_wvalid), 0);
        chk({tag, "_wlast"}, 64'(m_axi_wlast), 0);
        chk({tag, "_bready"}, 64'(m_axi_bready), 0);
        chk({tag, "_awaddr"}, 64'(m_axi_awaddr), 0);
        chk({tag, "_awlen"}, 64'(m_axi_awlen), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents traffic
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_hs = wlast_cnt;
            end else begin
                if (m_axi_awvalid) begin
                    if (exp_aw.size() == 0) begin
                        chk("aw_unexpected", 1, 0);
                    end else begin
                        chk("awaddr", 64'(m_axi_awaddr), 64'(exp_aw[0].addr));
                        chk("awlen", 64'(m_axi_awlen), 64'(exp_aw[0].len));
                        chk("awsize", 64'(m_axi_awsize), 2);
                        chk("awburst", 64'(m_axi_awburst), 1);
                        if (m_axi_awready) begin
                            void'(exp_aw.pop_front());
                            aw_hs++;
                        end
                    end
                end
                if (m_axi_wvalid) begin
                    chk("w_before_aw", 64'(aw_hs > wlast_cnt), 1);
                    if (m_axi_wready) begin
                        if (exp_w.size() == 0) begin
                            chk("w_unexpected", 1, 0);
                        end else begin
                            w_t e;
                            e = exp_w.pop_front();
                            chk("wdata", 64'(m_axi_wdata), 64'(e.data));
                            chk("wstrb", 64'(m_axi_wstrb), 64'(e.strb));
                            chk("wlast", 64'(m_axi_wlast), 64'(e.last));
                        end
                        w_hs++;
                        if (m_axi_wlast) wlast_cnt++;
                    end
                end
                if (m_axi_bvalid && m_axi_bready) b_hs++;
                if (done) begin
                    if (exp_err.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        chk("err_at_done", 64'(err), 64'(exp_err.pop_front()));
                    end
                    chk("aw_left_at_done", 64'(exp_aw.size()), 0);
                    chk("w_left_at_done", 64'(exp_w.size()), 0);
                    chk("busy_at_done", 64'(busy), 1);
                    done_cnt++;
                end
            end
        end
    end

    // AXI slave: random ready stalls, one B per completed burst
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axi_awready = (stall == 0) || ($urandom % 2 == 0);
            m_axi_wready  = (stall == 0) || ($urandom % 3 != 0);
            if (m_axi_bvalid && b_hs == b_issued) begin
                m_axi_bvalid = 1'b0;
            end else if (!m_axi_bvalid && wlast_cnt > b_issued
                         && (stall == 0 || $urandom % 2 == 0)) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
                b_issued++;
            end
        end
    end

    // Fires a start inside the done cycle; it must be ignored
    initial begin
        forever begin
            @(negedge clk);
            if (done && start_on_done) begin
                start_on_done = 1'b0;
                start = 1'b1;
                base_addr = 32'h0000_8000;
                @(posedge clk);
                #1;
                start = 1'b0;
                @(negedge clk);
                chk("start_in_done_ignored", 64'(busy), 0);
            end
        end
    end

    task automatic run_packet(int n, logic [AW-1:0] base, int bad,
                              logic [KW-1:0] lastkeep, bit rnd_keep);
        logic [DW-1:0] d[$];
        logic [KW-1:0] k[$];
        int nb, d0, w0, t;
        bit hs;
        nb = (n + BL - 1) / BL;
        for (int i = 0; i < n; i++) begin
            d.push_back($urandom);
            if (i == n - 1) k.push_back(lastkeep);
            else k.push_back(rnd_keep ? KW'($urandom) : '1);
        end
        for (int b = 0; b < nb; b++) begin
            aw_t a;
            int beats;
            beats = (n - b * BL < BL) ? n - b * BL : BL;
            a.addr = base + AW'(b * BL * KW);
            a.len = 8'(beats - 1);
            exp_aw.push_back(a);
            resp_q.push_back((b == bad) ? 2'b10 : 2'b00);
        end
        for (int i = 0; i < n; i++) begin
            w_t e;
            e.data = d[i];
            e.strb = k[i];
            e.last = (i % BL == BL - 1) || (i == n - 1);
            exp_w.push_back(e);
        end
        if (reset_at == 0) exp_err.push_back(bad >= 0 && bad < nb);
        d0 = done_cnt;
        w0 = w_hs;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 64'(busy), 1);
        chk("err_clear_on_start", 64'(err), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (stall != 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom % 3) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_axis_tdata  = d[i];
            s_axis_tkeep  = k[i];
            s_axis_tlast  = (i == n - 1);
            s_axis_tvalid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                hs = s_axis_tready;
                @(posedge clk);
                #1;
                t++;
            end while (!hs && t < 2000);
            if (!hs) begin
                chk("tready_timeout", 0, 1);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (reset_at != 0) begin
            t = 0;
            while (w_hs - w0 < reset_at && t < 2000) begin
                @(posedge clk);
                t++;
            end
            chk("reset_beat_reached", 64'(w_hs - w0 >= reset_at), 1);
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            chk_idle_outputs("midburst_reset");
            exp_aw.delete();
            exp_w.delete();
            resp_q.delete();
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            reset_at = 0;
        end else begin
            t = 0;
            while (done_cnt == d0 && t < 5000) begin
                @(posedge clk);
                t++;
            end
            chk("done_count", 64'(done_cnt), 64'(d0 + 1));
        end
    endtask

    initial begin
        int n, nb, bad;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        stall = 0;
        run_packet(32, 32'h0000_1000, -1, '1, 1'b0);
        start_on_done = 1'b1;
        run_packet(20, 32'h0000_0000, -1, '1, 1'b0);

        stall = 1;
        run_packet(40, 32'h0000_2040, -1, 4'b0111, 1'b1);
        run_packet(48, 32'h0001_0000, 1, '1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky_after_done", 64'(err), 1);
        run_packet(5, 32'h0001_0400, -1, '1, 1'b1);

        stall = 0;
        reset_at = 5;
        run_packet(16, 32'h0000_3000, -1, '1, 1'b0);
        run_packet(10, 32'h0000_3100, -1, '1, 1'b0);
        run_packet(1, 32'h0000_0040, -1, 4'b0011, 1'b0);
        run_packet(32, 32'hFFFF_FFC0, -1, '1, 1'b0);

        stall = 1;
        for (int p = 0; p < 6; p++) begin
            n = $urandom_range(1, 60);
            nb = (n + BL - 1) / BL;
            bad = int'($urandom_range(0, nb)) - 1;
            run_packet(n, {$urandom, 6'b0} & 32'hFFFF_FFC0, bad,
                       KW'($urandom_range(1, 15)), 1'b1);
        end

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
